// File: rtl/seg_hex_pkg.sv
// Shared types and the hex-to-7-segment glyph table for the seg_hex_scan display driver.
// Latency: combinational helpers only.
// Backpressure: none (package).
package seg_hex_pkg;

    // Segment order {g,f,e,d,c,b,a}, active-low (0 = segment lit)
    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'h7F;

    // Standard hex glyphs: 0..9, A, b, C, d, E, F
    function automatic seg7_t hex_to_seg(input logic [3:0] nib);
        seg7_t s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_hex_scan_timer.sv
// Scan timebase: prescaler, digit scan index, frame_end strobe; blink phase when SEG_HEX_BLINK_EN is defined.
// Latency: idx/blink_ph registered; frame_end is a combinational strobe during the index-wrap cycle.
// Backpressure: none, free-running.
module seg_hex_scan_timer #(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 64,
    localparam int IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [IW-1:0] idx,
    output logic          frame_end
`ifdef SEG_HEX_BLINK_EN
    ,
    output logic          blink_ph
`endif
);

    localparam int PW = $clog2(SCAN_DIV);

    logic [PW-1:0] pre;
    logic          tc;

    assign tc        = (pre == PW'(SCAN_DIV - 1));
    assign frame_end = tc && (idx == IW'(DIGITS - 1));

    // Prescaler counts 0..SCAN_DIV-1; its terminal count steps the scan index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
            idx <= '0;
        end else if (tc) begin
            pre <= '0;
            idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
        end else begin
            pre <= pre + PW'(1);
        end
    end

`ifdef SEG_HEX_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BW-1:0] fcnt;

    // Blink phase flips every BLINK_DIV frames, starting in the visible phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt     <= '0;
            blink_ph <= 1'b0;
        end else if (frame_end) begin
            if (fcnt == BW'(BLINK_DIV - 1)) begin
                fcnt     <= '0;
                blink_ph <= ~blink_ph;
            end else begin
                fcnt <= fcnt + BW'(1);
            end
        end
    end
`else
    localparam int unused_blink_div = BLINK_DIV;
`endif

endmodule

// File: rtl/seg_hex_scan.sv
// Multi-digit hex 7-seg driver: double-buffered word committed only at frame boundaries; static + scanned outputs. Optional blink: SEG_HEX_BLINK_EN.
// Latency: HEX_ALL 1 clk after commit/blank_lz change; SEG/DIG_N 1 clk after scan index change; load commits at the next frame_end.
// Backpressure: ld_ready low while a word is pending; ld_valid is not sampled until the pending word commits.
module seg_hex_scan
    import seg_hex_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [4*DIGITS-1:0]   ld_data,
    input  logic                  blank_lz,
    input  logic [DIGITS-1:0]     blink_msk,
    output logic [7*DIGITS-1:0]   HEX_ALL,
    output logic [6:0]            SEG,
    output logic [DIGITS-1:0]     DIG_N
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [IW-1:0]       idx;
    logic                frame_end;
    logic [4*DIGITS-1:0] pend;
    logic [4*DIGITS-1:0] shown;
    logic                pend_full;
    logic                shown_vld;
    seg7_t               dig_seg [DIGITS];

`ifdef SEG_HEX_BLINK_EN
    logic blink_ph;
`else
    logic unused_blink_msk;
    assign unused_blink_msk = ^blink_msk;
`endif

    seg_hex_scan_timer #(
        .DIGITS    (DIGITS),
        .SCAN_DIV  (SCAN_DIV),
        .BLINK_DIV (BLINK_DIV)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .idx       (idx),
        .frame_end (frame_end)
`ifdef SEG_HEX_BLINK_EN
        ,
        .blink_ph  (blink_ph)
`endif
    );

    assign ld_ready = ~pend_full;

    // Accept into the pending buffer; move pending to shown only at frame_end so the display never tears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend      <= '0;
            shown     <= '0;
            pend_full <= 1'b0;
            shown_vld <= 1'b0;
        end else if (ld_valid && !pend_full) begin
            pend      <= ld_data;
            pend_full <= 1'b1;
        end else if (frame_end && pend_full) begin
            shown     <= pend;
            shown_vld <= 1'b1;
            pend_full <= 1'b0;
        end
    end

    // Per-digit glyph with blanking; zero_run tracks "all nibbles from the top down to here are 0"
    always_comb begin
        logic       zero_run;
        logic       blank;
        logic [3:0] nib;
        dig_seg  = '{default: SEG_BLANK};
        zero_run = 1'b1;
        blank    = 1'b0;
        nib      = 4'h0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nib      = shown[4*i +: 4];
            zero_run = zero_run && (nib == 4'h0);
            blank    = !shown_vld || (blank_lz && (i > 0) && zero_run);
`ifdef SEG_HEX_BLINK_EN
            blank    = blank || (blink_msk[i] && blink_ph);
`endif
            dig_seg[i] = blank ? SEG_BLANK : hex_to_seg(nib);
        end
    end

    // Registered outputs; SEG and DIG_N switch on the same edge so no digit shows its neighbour's glyph
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            HEX_ALL <= '1;
            SEG     <= SEG_BLANK;
            DIG_N   <= '1;
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                HEX_ALL[7*i +: 7] <= dig_seg[i];
            end
            SEG   <= dig_seg[idx];
            DIG_N <= ~(DIGITS'(1) << idx);
        end
    end

endmodule

// File: tb/tb_seg_hex_scan.sv
// Directed bench for seg_hex_scan (DIGITS=4, SCAN_DIV=4, BLINK_DIV=2).
// Cycle numbering: cyc = number of rising edges since the last reset release; a frame is 16 cycles.
// frame_end occurs in cycles 15, 31, 47, ...; a commit is visible on HEX_ALL two cycles later.
module tb_seg_hex_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld_valid;
    logic        ld_ready;
    logic [15:0] ld_data;
    logic        blank_lz;
    logic [3:0]  blink_msk;
    logic [27:0] HEX_ALL;
    logic [6:0]  SEG;
    logic [3:0]  DIG_N;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    seg_hex_scan #(
        .DIGITS    (4),
        .SCAN_DIV  (4),
        .BLINK_DIV (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_data   (ld_data),
        .blank_lz  (blank_lz),
        .blink_msk (blink_msk),
        .HEX_ALL   (HEX_ALL),
        .SEG       (SEG),
        .DIG_N     (DIG_N)
    );

    always #5 clk = ~clk;

    // Blink expectation for digit 0 when its phase is "off"
`ifdef SEG_HEX_BLINK_EN
    localparam logic [6:0] D0_BLINK = 7'h7F;
`else
    localparam logic [6:0] D0_BLINK = 7'h0E;
`endif

    task automatic check(input string tag, input logic [27:0] obs, input logic [27:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic goto(input int target);
        if (target > cyc) step(target - cyc);
    endtask

    initial begin
        rst_n     = 1'b0;
        ld_valid  = 1'b0;
        ld_data   = 16'h0000;
        blank_lz  = 1'b0;
        blink_msk = 4'b0000;
        step(3);
        rst_n = 1'b1;
        cyc   = 0;

        // 1: reset state and free-running scan with nothing shown
        check("rst_hex", HEX_ALL, 28'hFFFFFFF);
        check("rst_seg", {21'd0, SEG}, {21'd0, 7'h7F});
        check("rst_dig", {24'd0, DIG_N}, {24'd0, 4'b1111});
        check("rst_rdy", {27'd0, ld_ready}, 28'd1);
        for (int k = 1; k <= 17; k++) begin
            logic [3:0] exp_dig;
            step(1);
            exp_dig = ~(4'b0001 << (((k - 1) / 4) % 4));
            check("scan_dig", {24'd0, DIG_N}, {24'd0, exp_dig});
            check("scan_seg", {21'd0, SEG}, {21'd0, 7'h7F});
        end

        // 2: load 1A3F mid-frame
        ld_valid = 1'b1;
        ld_data  = 16'h1A3F;
        step(1);
        ld_valid = 1'b0;
        check("ld_rdy_drop", {27'd0, ld_ready}, 28'd0);
        goto(32);
        check("ld_rdy_back", {27'd0, ld_ready}, 28'd1);
        check("hex_pre_commit", HEX_ALL, 28'hFFFFFFF);
        step(1);
        check("hex_1a3f", HEX_ALL, {7'h79, 7'h08, 7'h30, 7'h0E});
        check("seg_d0_F", {21'd0, SEG}, {21'd0, 7'h0E});
        check("dig_d0", {24'd0, DIG_N}, {24'd0, 4'b1110});
        goto(37);
        check("seg_d1_3", {21'd0, SEG}, {21'd0, 7'h30});
        check("dig_d1", {24'd0, DIG_N}, {24'd0, 4'b1101});

        // 3: back-pressure, second word waits for the first to commit
        goto(34);
        ld_valid = 1'b1;
        ld_data  = 16'h1111;
        step(1);
        ld_data = 16'h2222;
        check("bp_rdy_low", {27'd0, ld_ready}, 28'd0);
        goto(47);
        check("bp_rdy_hold", {27'd0, ld_ready}, 28'd0);
        check("bp_hex_old", HEX_ALL, {7'h79, 7'h08, 7'h30, 7'h0E});
        step(1);
        check("bp_rdy_free", {27'd0, ld_ready}, 28'd1);
        step(1);
        ld_valid = 1'b0;
        check("bp_rdy_2222", {27'd0, ld_ready}, 28'd0);
        check("bp_hex_1111", HEX_ALL, {7'h79, 7'h79, 7'h79, 7'h79});
        goto(64);
        check("bp_1111_last", HEX_ALL, {7'h79, 7'h79, 7'h79, 7'h79});
        step(1);
        check("bp_hex_2222", HEX_ALL, {7'h24, 7'h24, 7'h24, 7'h24});

        // 4: leading-zero blanking
        blank_lz = 1'b1;
        step(1);
        check("lz_no_zero", HEX_ALL, {7'h24, 7'h24, 7'h24, 7'h24});
        ld_valid = 1'b1;
        ld_data  = 16'h0050;
        step(1);
        ld_valid = 1'b0;
        goto(81);
        check("lz_0050", HEX_ALL, {7'h7F, 7'h7F, 7'h12, 7'h40});
        ld_valid = 1'b1;
        ld_data  = 16'h0000;
        step(1);
        ld_valid = 1'b0;
        goto(97);
        check("lz_0000", HEX_ALL, {7'h7F, 7'h7F, 7'h7F, 7'h40});
        check("lz_seg_d0", {21'd0, SEG}, {21'd0, 7'h40});
        goto(109);
        check("lz_seg_d3", {21'd0, SEG}, {21'd0, 7'h7F});
        check("lz_dig_d3", {24'd0, DIG_N}, {24'd0, 4'b0111});
        blank_lz = 1'b0;
        step(1);
        check("lz_off", HEX_ALL, {7'h40, 7'h40, 7'h40, 7'h40});

        // 5: asynchronous reset mid-cycle with a word pending
        ld_valid = 1'b1;
        ld_data  = 16'h1234;
        step(1);
        ld_valid = 1'b0;
        check("ar_pend", {27'd0, ld_ready}, 28'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_hex", HEX_ALL, 28'hFFFFFFF);
        check("ar_seg", {21'd0, SEG}, {21'd0, 7'h7F});
        check("ar_dig", {24'd0, DIG_N}, {24'd0, 4'b1111});
        check("ar_rdy", {27'd0, ld_ready}, 28'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        goto(17);
        check("ar_post_hex", HEX_ALL, 28'hFFFFFFF);
        check("ar_post_dig", {24'd0, DIG_N}, {24'd0, 4'b1110});
        check("ar_post_seg", {21'd0, SEG}, {21'd0, 7'h7F});
        goto(34);
        check("ar_no_commit", HEX_ALL, 28'hFFFFFFF);

        // 6: blink on digit 0 (phase visible frames 0-1, blank frames 2-3, ...)
        blink_msk = 4'b0001;
        ld_valid  = 1'b1;
        ld_data   = 16'h1A3F;
        step(1);
        ld_valid = 1'b0;
        goto(49);
        check("bl_off1", HEX_ALL, {7'h79, 7'h08, 7'h30, D0_BLINK});
        goto(64);
        check("bl_off2", HEX_ALL, {7'h79, 7'h08, 7'h30, D0_BLINK});
        step(1);
        check("bl_on", HEX_ALL, {7'h79, 7'h08, 7'h30, 7'h0E});
        goto(97);
        check("bl_off3", HEX_ALL, {7'h79, 7'h08, 7'h30, D0_BLINK});
        check("bl_seg_d0", {21'd0, SEG}, {21'd0, D0_BLINK});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
